// File: rtl/wb_pkg.sv
// Shared types and constants for the DDR3 write-back path.
package wb_pkg;

    localparam int PIX_PER_WORD = 4;
    localparam int PIX_W        = 32;
    localparam int AVL_DATA_W   = 128;
    localparam int AVL_ADDR_W   = 26;
    localparam int DIM_W        = 10;   // width of stride and rows
    localparam int CNT_W        = 20;   // width of word counters (stride x rows)
    localparam int LANE_W       = 2;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } wb_state_t;

    // Number of 128-bit words in a stride x rows region, computed at full width.
    function automatic logic [CNT_W-1:0] region_words(input logic [DIM_W-1:0] stride,
                                                      input logic [DIM_W-1:0] rows);
        logic [CNT_W-1:0] s;
        logic [CNT_W-1:0] r;
        s = {{(CNT_W-DIM_W){1'b0}}, stride};
        r = {{(CNT_W-DIM_W){1'b0}}, rows};
        return s * r;
    endfunction

endpackage

// File: rtl/write_buffer_if.sv
// Control, pixel-stream and Avalon-MM write signals of the write buffer.
// The master modport is the write buffer itself (it masters the Avalon bus);
// the slave modport is the surrounding system: control, ALU and DDR3 controller.
interface write_buffer_if
    import wb_pkg::*;
#(
    parameter int ADDR_W = AVL_ADDR_W
) ();

    // transfer control
    logic                  start;
    logic [ADDR_W-1:0]     start_address;
    logic [DIM_W-1:0]      stride;
    logic [DIM_W-1:0]      rows;
    logic                  ready;
    logic                  done;

    // pixel stream from the ALU
    logic                  in_valid;
    logic [PIX_W-1:0]      in_data;
    logic                  in_ready;

    // Avalon-MM write master
    logic [ADDR_W-1:0]     avl_address;
    logic [AVL_DATA_W-1:0] avl_writedata;
    logic                  avl_write;
    logic                  avl_read;
    logic                  avl_burstbegin;
    logic                  avl_wait_request_n;

    modport master (
        input  start, start_address, stride, rows,
        output ready, done,
        input  in_valid, in_data,
        output in_ready,
        output avl_address, avl_writedata, avl_write, avl_read, avl_burstbegin,
        input  avl_wait_request_n
    );

    modport slave (
        output start, start_address, stride, rows,
        input  ready, done,
        output in_valid, in_data,
        input  in_ready,
        input  avl_address, avl_writedata, avl_write, avl_read, avl_burstbegin,
        output avl_wait_request_n
    );

endinterface

// File: rtl/wb_fifo.sv
// Synchronous show-ahead FIFO: head always shows the oldest entry while not empty.
// Reset flushes the contents by clearing pointers and level.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int WIDTH = AVL_DATA_W,
    parameter int DEPTH = 16
) (
    input  logic                     iCLK,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic                     empty,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int            AW         = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_LEVEL = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW:0]      level;
    logic             do_push;
    logic             do_pop;

    // A push into a full FIFO is only taken when a pop frees a slot in the same cycle.
    assign do_push = push && (!full || pop);
    assign do_pop  = pop && !empty;

    // Storage write port.
    // NOTE: the storage array has no reset; flushing only needs the pointers and
    // level cleared, and leaving the array out of reset lets it map to RAM.
    always_ff @(posedge iCLK) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally (DEPTH is a power of two).
    // NOTE: sequential state is always assigned with <= so every register samples
    // its inputs from before the edge, independent of statement order.
    always_ff @(posedge iCLK) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign head  = mem[rd_ptr];
    assign empty = (level == '0);
    assign full  = (level == FULL_LEVEL);
    assign count = level;

endmodule

// File: rtl/write_buffer.sv
// DDR3 write-back stage: packs four 32-bit pixels per 128-bit word, queues the
// words and writes them to a linear region starting at start_address through an
// Avalon-MM master with single-beat bursts.
module write_buffer
    import wb_pkg::*;
#(
    parameter int FIFO_DEPTH = 16,
    parameter int ADDR_W     = AVL_ADDR_W
) (
    input  logic           iCLK,
    input  logic           reset,
    write_buffer_if.master bus
);

    localparam int FCNT_W = $clog2(FIFO_DEPTH) + 1;

    wb_state_t                  state;
    logic                       ready_q;
    logic                       done_q;
    logic [CNT_W-1:0]           total_q;
    logic [CNT_W-1:0]           words_in_q;
    logic [CNT_W-1:0]           words_out_q;
    logic [LANE_W-1:0]          lane_q;
    logic [(PIX_PER_WORD-1)*PIX_W-1:0] pack_q;   // lanes 0..2 of the word being built
    logic [ADDR_W-1:0]          addr_q;

    logic [CNT_W-1:0]           start_total;
    logic                       in_ready_c;
    logic                       pix_fire;
    logic                       word_push;
    logic [AVL_DATA_W-1:0]      word_data;
    logic                       wr_fire;
    logic                       last_out;

    logic [AVL_DATA_W-1:0]      fifo_head;
    logic                       fifo_empty;
    logic                       fifo_full;
    logic [FCNT_W-1:0]          fifo_count;

    assign start_total = region_words(bus.stride, bus.rows);

    // Accept pixels only while running, with FIFO room, and never beyond the region.
    assign in_ready_c = (state == RUN) && !fifo_full && (words_in_q < total_q);
    assign pix_fire   = bus.in_valid && in_ready_c;

    // The fourth pixel completes the word; it lands in the top lane.
    assign word_push  = pix_fire && (lane_q == LANE_W'(PIX_PER_WORD-1));
    assign word_data  = {bus.in_data, pack_q};

    // A write is presented whenever the FIFO holds a word; it completes when the
    // slave is not stalling, which pops the head and advances the address.
    assign wr_fire    = bus.avl_write && bus.avl_wait_request_n;
    assign last_out   = (words_out_q == total_q - 1'b1);

    wb_fifo #(
        .WIDTH (AVL_DATA_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .iCLK      (iCLK),
        .reset     (reset),
        .push      (word_push),
        .push_data (word_data),
        .pop       (wr_fire),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .full      (fifo_full),
        .count     (fifo_count)
    );

    // Transfer FSM with packer, word counters and Avalon address generator.
    always_ff @(posedge iCLK) begin
        if (reset) begin
            state       <= IDLE;
            ready_q     <= 1'b1;
            done_q      <= 1'b0;
            total_q     <= '0;
            words_in_q  <= '0;
            words_out_q <= '0;
            lane_q      <= '0;
            pack_q      <= '0;
            addr_q      <= '0;
        end else begin
            done_q <= 1'b0;

            // Packer: lanes 0..2 are stored, lane 3 goes straight into the FIFO.
            if (pix_fire) begin
                if (word_push) begin
                    lane_q     <= '0;
                    words_in_q <= words_in_q + 1'b1;
                end else begin
                    lane_q                     <= lane_q + 1'b1;
                    pack_q[PIX_W*lane_q +: PIX_W] <= bus.in_data;
                end
            end

            // Address wraps silently modulo 2^ADDR_W.
            if (wr_fire) begin
                addr_q      <= addr_q + 1'b1;
                words_out_q <= words_out_q + 1'b1;
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        addr_q      <= bus.start_address;
                        total_q     <= start_total;
                        words_in_q  <= '0;
                        words_out_q <= '0;
                        lane_q      <= '0;
                        ready_q     <= 1'b0;
                        if (start_total == '0) begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end else begin
                            state  <= RUN;
                        end
                    end
                end
                RUN: begin
                    // The last write can complete before DRAIN is ever entered.
                    if (wr_fire && last_out) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end else if (words_in_q == total_q) begin
                        state  <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (wr_fire && last_out) begin
                        state  <= DONE;
                        done_q <= 1'b1;
                    end
                end
                DONE: begin
                    ready_q <= 1'b1;
                    state   <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready          = ready_q;
    assign bus.done           = done_q;
    assign bus.in_ready       = in_ready_c;
    assign bus.avl_address    = addr_q;
    assign bus.avl_write      = (fifo_count != '0);
    assign bus.avl_writedata  = fifo_empty ? '0 : fifo_head;
    assign bus.avl_read       = 1'b0;
    assign bus.avl_burstbegin = bus.avl_write;

endmodule
